// File: rtl/pulse_event_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pulse_event_arbiter: per-channel edge/pulse detect, pending latch and
// round-robin valid/ready event output. Optional: PULSE_ARB_DROP_CNT_EN. Rev 1.0
// ----------------------------------------------------------------------------
module pulse_event_arbiter #(
  parameter  int N_CH = 4,
  localparam int CH_W = $clog2(N_CH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] a,
  input  logic [N_CH-1:0] ch_en,
  input  logic [N_CH-1:0] mode,
  output logic            evt_valid,
  output logic [CH_W-1:0] evt_ch,
  input  logic            evt_ready,
  output logic [N_CH-1:0] ovf,
  input  logic            ovf_clr
`ifdef PULSE_ARB_DROP_CNT_EN
  ,
  output logic [7:0]      drop_cnt
`endif
);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_OFFER = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [N_CH-1:0] h1_q, h1_d;
  logic [N_CH-1:0] h2_q, h2_d;
  logic [N_CH-1:0] pend_q, pend_d;
  logic [N_CH-1:0] ovf_q, ovf_d;
  logic [CH_W-1:0] g_q, g_d;
  logic [CH_W-1:0] ptr_q, ptr_d;

  logic [N_CH-1:0] det;
  logic [N_CH-1:0] clr_vec;
  logic [N_CH-1:0] ovf_set;
  logic            accept;

  // First requesting channel at or after start, wrapping modulo N_CH.
  function automatic logic [CH_W-1:0] rr_pick(input logic [N_CH-1:0] req,
                                              input logic [CH_W-1:0] start);
    int   idx;
    logic found;
    rr_pick = '0;
    found   = 1'b0;
    for (int k = 0; k < N_CH; k++) begin
      idx = (int'(start) + k) % N_CH;
      if (!found && req[idx]) begin
        rr_pick = idx[CH_W-1:0];
        found   = 1'b1;
      end
    end
  endfunction

  function automatic logic [CH_W-1:0] wrap_inc(input logic [CH_W-1:0] v);
    int nxt;
    nxt = (int'(v) + 1) % N_CH;
    return nxt[CH_W-1:0];
  endfunction

  always_comb begin
    h1_d    = a;
    h2_d    = h1_q;
    det     = ch_en & ((~mode & a & ~h1_q) | (mode & ~a & h1_q & ~h2_q));
    accept  = (state_q == S_OFFER) && evt_ready;
    clr_vec = '0;
    if (accept) clr_vec[g_q] = 1'b1;
    // A re-detection on the channel being accepted keeps it pending.
    pend_d  = (pend_q & ~clr_vec) | det;
    ovf_set = det & pend_q & ~clr_vec;
    ovf_d   = (ovf_clr ? '0 : ovf_q) | ovf_set;
  end

  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    ptr_d   = ptr_q;
    case (state_q)
      S_IDLE: begin
        if (|pend_q) begin
          g_d     = rr_pick(pend_q, ptr_q);
          state_d = S_OFFER;
        end
      end
      S_OFFER: begin
        // Grant is frozen until the consumer takes it.
        if (evt_ready) begin
          ptr_d = wrap_inc(g_q);
          if (|pend_d) g_d = rr_pick(pend_d, wrap_inc(g_q));
          else         state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      h1_q    <= '0;
      h2_q    <= '0;
      pend_q  <= '0;
      ovf_q   <= '0;
      g_q     <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      h1_q    <= h1_d;
      h2_q    <= h2_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      g_q     <= g_d;
      ptr_q   <= ptr_d;
    end
  end

  assign evt_valid = (state_q == S_OFFER);
  assign evt_ch    = g_q;
  assign ovf       = ovf_q;

`ifdef PULSE_ARB_DROP_CNT_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;
  logic [8:0] drop_sum;

  // Clear first, then add this cycle's overflows, so the increment survives a clear.
  always_comb begin
    drop_sum = ovf_clr ? 9'd0 : {1'b0, drop_cnt_q};
    for (int i = 0; i < N_CH; i++) begin
      drop_sum = drop_sum + {8'd0, ovf_set[i]};
    end
    drop_cnt_d = (drop_sum > 9'd255) ? 8'hFF : drop_sum[7:0];
  end

  always_ff @(posedge clk) begin
    if (!rst) drop_cnt_q <= '0;
    else      drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt = drop_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pulse_event_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_pulse_event_arbiter: directed vector table plus randomized run against a
// behavioural model. Optional: PULSE_ARB_DROP_CNT_EN. Rev 1.0
// ----------------------------------------------------------------------------
module tb_pulse_event_arbiter;
  localparam int N  = 4;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  a, ch_en, mode, ovf;
  logic          evt_valid, evt_ready, ovf_clr;
  logic [CW-1:0] evt_ch;
`ifdef PULSE_ARB_DROP_CNT_EN
  logic [7:0]    drop_cnt;
`endif

  always #5 clk = ~clk;

  pulse_event_arbiter #(.N_CH(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .ch_en     (ch_en),
    .mode      (mode),
    .evt_valid (evt_valid),
    .evt_ch    (evt_ch),
    .evt_ready (evt_ready),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr)
`ifdef PULSE_ARB_DROP_CNT_EN
    ,
    .drop_cnt  (drop_cnt)
`endif
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: plain arrays and integer search over channel indices.
  bit [N-1:0] m_h1, m_h2, m_pend, m_ovf;
  bit         m_offer;
  int         m_g, m_ptr, m_drop;

  function automatic int first_from(input bit [N-1:0] req, input int start);
    for (int k = 0; k < N; k++) begin
      if (req[(start + k) % N]) return (start + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_h1 = '0; m_h2 = '0; m_pend = '0; m_ovf = '0;
    m_offer = 1'b0; m_g = 0; m_ptr = 0; m_drop = 0;
  endtask

  task automatic model_step();
    bit [N-1:0] det, np, no;
    int         n;
    if (!rst) begin
      model_reset();
    end else begin
      n = 0;
      for (int i = 0; i < N; i++) begin
        if (mode[i]) det[i] = ch_en[i] && !a[i] && m_h1[i] && !m_h2[i];
        else         det[i] = ch_en[i] && a[i] && !m_h1[i];
        if (det[i]) begin
          np[i] = 1'b1;
        end else if (m_offer && evt_ready && i == m_g) begin
          np[i] = 1'b0;
        end else begin
          np[i] = m_pend[i];
        end
        no[i] = ovf_clr ? 1'b0 : m_ovf[i];
        if (det[i] && m_pend[i] && !(m_offer && evt_ready && i == m_g)) begin
          no[i] = 1'b1;
          n++;
        end
      end
      m_drop = (ovf_clr ? 0 : m_drop) + n;
      if (m_drop > 255) m_drop = 255;
      if (!m_offer) begin
        if (m_pend != 0) begin
          m_g     = first_from(m_pend, m_ptr);
          m_offer = 1'b1;
        end
      end else if (evt_ready) begin
        m_ptr = (m_g + 1) % N;
        if (np != 0) m_g = first_from(np, m_ptr);
        else         m_offer = 1'b0;
      end
      m_pend = np;
      m_ovf  = no;
      m_h2   = m_h1;
      m_h1   = a;
    end
  endtask

  task automatic model_check();
    chk("model valid", int'(evt_valid), int'(m_offer));
    if (m_offer) chk("model ch", int'(evt_ch), m_g);
    chk("model ovf", int'(ovf), int'(m_ovf));
`ifdef PULSE_ARB_DROP_CNT_EN
    chk("model drop_cnt", int'(drop_cnt), m_drop);
`endif
  endtask

  task automatic cycle_post();
    model_check();
    model_step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit       rstn;
    bit [3:0] a;
    bit [3:0] mode;
    bit       rdy;
    bit       clr;
    bit       ev;
    int       ec;
    bit [3:0] eo;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input bit rn, input bit [3:0] av, input bit [3:0] md,
                              input bit rd, input bit cl, input bit ev, input int ec,
                              input bit [3:0] eo);
    vec_t v;
    v.rstn = rn; v.a = av; v.mode = md; v.rdy = rd; v.clr = cl;
    v.ev = ev; v.ec = ec; v.eo = eo;
    tbl.push_back(v);
  endfunction

  initial begin
    rst = 1'b0; a = '0; ch_en = '1; mode = '0; evt_ready = 1'b1; ovf_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();

    // Single rising edge on ch2, held high: one event at t0+2.
    add(0, 4'h0, 4'h0, 1, 0, 0, 0, 4'h0);
    add(1, 4'h4, 4'h0, 1, 0, 0, 0, 4'h0);
    add(1, 4'h4, 4'h0, 1, 0, 0, 0, 4'h0);
    add(1, 4'h4, 4'h0, 1, 0, 1, 2, 4'h0);
    add(1, 4'h4, 4'h0, 1, 0, 0, 0, 4'h0);
    // Reset, then ch0/1/3 together twice: order 0,1,3 both times.
    add(0, 4'h0, 4'h0, 1, 0, 0, 0, 4'h0);
    add(1, 4'hB, 4'h0, 1, 0, 0, 0, 4'h0);
    add(1, 4'hB, 4'h0, 1, 0, 0, 0, 4'h0);
    add(1, 4'hB, 4'h0, 1, 0, 1, 0, 4'h0);
    add(1, 4'hB, 4'h0, 1, 0, 1, 1, 4'h0);
    add(1, 4'hB, 4'h0, 1, 0, 1, 3, 4'h0);
    add(1, 4'h0, 4'h0, 1, 0, 0, 0, 4'h0);
    add(1, 4'hB, 4'h0, 1, 0, 0, 0, 4'h0);
    add(1, 4'hB, 4'h0, 1, 0, 0, 0, 4'h0);
    add(1, 4'hB, 4'h0, 1, 0, 1, 0, 4'h0);
    add(1, 4'hB, 4'h0, 1, 0, 1, 1, 4'h0);
    add(1, 4'hB, 4'h0, 1, 0, 1, 3, 4'h0);
    add(1, 4'h0, 4'h0, 1, 0, 0, 0, 4'h0);
    // ch3 offered under ready=0, ch0 arrives meanwhile.
    add(1, 4'h8, 4'h0, 0, 0, 0, 0, 4'h0);
    add(1, 4'h8, 4'h0, 0, 0, 0, 0, 4'h0);
    add(1, 4'h9, 4'h0, 0, 0, 1, 3, 4'h0);
    add(1, 4'h9, 4'h0, 0, 0, 1, 3, 4'h0);
    add(1, 4'h9, 4'h0, 1, 0, 1, 3, 4'h0);
    add(1, 4'h9, 4'h0, 1, 0, 1, 0, 4'h0);
    add(1, 4'h0, 4'h0, 1, 0, 0, 0, 4'h0);
    // Overflow on ch2; clear coinciding with a third edge leaves it set.
    add(1, 4'h4, 4'h0, 0, 0, 0, 0, 4'h0);
    add(1, 4'h0, 4'h0, 0, 0, 0, 0, 4'h0);
    add(1, 4'h4, 4'h0, 0, 0, 1, 2, 4'h0);
    add(1, 4'h0, 4'h0, 0, 0, 1, 2, 4'h4);
    add(1, 4'h4, 4'h0, 0, 1, 1, 2, 4'h4);
    add(1, 4'h0, 4'h0, 0, 0, 1, 2, 4'h4);
    add(1, 4'h0, 4'h0, 1, 0, 1, 2, 4'h4);
    add(1, 4'h0, 4'h0, 1, 1, 0, 0, 4'h4);
    add(1, 4'h0, 4'h0, 1, 0, 0, 0, 4'h0);
    // Reset during an offer; held-high ch1 gives a fresh edge afterwards.
    add(1, 4'h2, 4'h0, 0, 0, 0, 0, 4'h0);
    add(1, 4'h2, 4'h0, 0, 0, 0, 0, 4'h0);
    add(1, 4'h2, 4'h0, 0, 0, 1, 1, 4'h0);
    add(0, 4'h2, 4'h0, 0, 0, 1, 1, 4'h0);
    add(1, 4'h2, 4'h0, 0, 0, 0, 0, 4'h0);
    add(1, 4'h2, 4'h0, 0, 0, 0, 0, 4'h0);
    add(1, 4'h2, 4'h0, 1, 0, 1, 1, 4'h0);
    add(1, 4'h0, 4'h0, 1, 0, 0, 0, 4'h0);
    // Pulse mode on ch1: 1-cycle pulse, 3-cycle high, then 1,0,1,0.
    add(1, 4'h0, 4'h2, 1, 0, 0, 0, 4'h0);
    add(1, 4'h2, 4'h2, 1, 0, 0, 0, 4'h0);
    add(1, 4'h0, 4'h2, 1, 0, 0, 0, 4'h0);
    add(1, 4'h0, 4'h2, 1, 0, 0, 0, 4'h0);
    add(1, 4'h0, 4'h2, 1, 0, 1, 1, 4'h0);
    add(1, 4'h2, 4'h2, 1, 0, 0, 0, 4'h0);
    add(1, 4'h2, 4'h2, 1, 0, 0, 0, 4'h0);
    add(1, 4'h2, 4'h2, 1, 0, 0, 0, 4'h0);
    add(1, 4'h0, 4'h2, 1, 0, 0, 0, 4'h0);
    add(1, 4'h2, 4'h2, 1, 0, 0, 0, 4'h0);
    add(1, 4'h0, 4'h2, 1, 0, 0, 0, 4'h0);
    add(1, 4'h2, 4'h2, 1, 0, 0, 0, 4'h0);
    add(1, 4'h0, 4'h2, 1, 0, 1, 1, 4'h0);
    add(1, 4'h0, 4'h2, 1, 0, 1, 1, 4'h0);
    add(1, 4'h0, 4'h2, 1, 0, 0, 0, 4'h0);

    foreach (tbl[k]) begin
      rst = tbl[k].rstn; a = tbl[k].a; mode = tbl[k].mode;
      evt_ready = tbl[k].rdy; ovf_clr = tbl[k].clr; ch_en = '1;
      @(negedge clk);
      chk($sformatf("row%0d valid", k), int'(evt_valid), int'(tbl[k].ev));
      if (tbl[k].ev) chk($sformatf("row%0d ch", k), int'(evt_ch), tbl[k].ec);
      chk($sformatf("row%0d ovf", k), int'(ovf), int'(tbl[k].eo));
      cycle_post();
    end

`ifdef PULSE_ARB_DROP_CNT_EN
    // After the overflow sequence's clear-with-set, then a plain clear.
    chk("drop_cnt after table", int'(drop_cnt), 0);
`endif

    for (int c = 0; c < 3000; c++) begin
      rst       = ($urandom_range(0, 199) != 0);
      a         = a ^ N'($urandom & $urandom);
      evt_ready = ($urandom_range(0, 3) != 0);
      ovf_clr   = ($urandom_range(0, 15) == 0);
      if (c % 25 == 0) begin
        mode  = N'($urandom);
        ch_en = ($urandom_range(0, 3) == 0) ? N'($urandom) : '1;
      end
      @(negedge clk);
      if (evt_valid) chk("ch range", int'(evt_ch < CW'(N - 1) || evt_ch == CW'(N - 1)), 1);
      cycle_post();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/pulse_event_arbiter.md
Name: pulse_event_arbiter

Overview:
- Multi-channel event front end and scheduler. Each of N_CH input lines has its own edge or one-cycle-pulse detector.
- Each detected event is latched as a pending request.
- A round-robin scheduler shares a single event output port (valid/ready) among the channels.
- Sits between raw strobe/status lines and a single downstream consumer, e.g. an interrupt or log sequencer.

Parameters:
- N_CH, 4, number of input channels (2..16).
- CH_W, $clog2(N_CH), width of channel index output (derived, not overridden).

Ports:
- clk  input  1  clock; all logic on posedge.
- rst  input  1  synchronous reset, active-low: rst==0 at posedge resets.
- a  input  N_CH  raw event lines, one per channel, synchronous to clk.
- ch_en  input  N_CH  per-channel detect enable.
- mode  input  N_CH  per-channel detect mode: 0 = rising edge, 1 = one-cycle pulse.
- evt_valid  output  1  an event is offered.
- evt_ch  output  CH_W  channel index of offered event.
- evt_ready  input  1  consumer accepts the offered event.
- ovf  output  N_CH  sticky per-channel overflow flags.
- ovf_clr  input  1  clears all ovf bits.

Behaviour:
- Per-channel history registers h1 (a delayed 1 cycle) and h2 (a delayed 2 cycles). Reset value 0.
- Detection is combinational (Mealy), evaluated in cycle t:
  - Edge mode: det = a & ~h1.
  - Pulse mode: det = ~a & h1 & ~h2, i.e. pattern 0,1,0; flags the falling cycle of an exactly-one-cycle-high pulse. Highs of 2+ cycles are not detected.
  - det is masked by ch_en.
  - Input high in the first cycle after reset counts as a rising edge (h1=0).
- Pending register pend[N_CH], reset 0.
  - Set at end of cycle t on det.
  - Cleared when its event is accepted (evt_valid & evt_ready & evt_ch==i).
  - Accept and det on the same channel in the same cycle: pend stays 1, no overflow.
- Overflow: det on channel i while pend[i]==1 and not cleared that cycle sets ovf[i].
  - ovf_clr clears all bits.
  - Set wins over clear for a bit in the same cycle. Reset 0.
- Round-robin pointer ptr (CH_W bits), reset 0. Search order is ptr, ptr+1, ..., wrapping modulo N_CH.
- FSM states IDLE, OFFER. Reset to IDLE. evt_valid = (state==OFFER). evt_ch = registered grant g, reset 0.
  - IDLE: if any pend, then g <= first pending in search order, go OFFER; else stay.
  - OFFER, evt_ready==0: hold g and evt_valid. evt_ch must not change while valid & ~ready, regardless of new pends.
  - OFFER, evt_ready==1: clear pend[g] (subject to the same-cycle rule above), ptr <= (g+1) mod N_CH.
    - If any other pend bit remains (including dets this cycle, excluding g unless re-detected), g <= first pending searched from g+1 and stay OFFER. This gives back-to-back, one event per cycle.
    - Otherwise go IDLE.
- Latency: det in cycle t gives pend at t+1, evt_valid at t+2 (from IDLE). Min 2 cycles, detect to offer.
- Disabling ch_en does not clear an existing pend bit; that bit is still served.
- Reset mid-offer: all state, pend, ovf and history return to reset values at that edge; the offered event is dropped.
- Non-power-of-2 N_CH: pointer wraps N_CH-1 to 0. Indices >= N_CH are never produced.

Optional Feature:
- Macro PULSE_ARB_DROP_CNT_EN.
- Defined: adds output drop_cnt [7:0], reset 0.
  - Increments by the number of channels that set ovf conditions in that cycle.
  - Saturates at 255.
  - Cleared by ovf_clr; increment wins over the clear, so the cycle's count is loaded.
- Undefined: port and logic absent; ovf behaviour unchanged.

Test Plan:
- N_CH=4, all edge mode, ready=1: a[2] rises at t0 and stays high. Expect evt_valid=1, evt_ch=2 at t0+2 for exactly 1 cycle; no further events.
- Pulse mode ch1: 1-cycle high at t0 gives one event ch1. 3-cycle high gives no event. Pattern 1,0,1,0 gives two events.
- a[0], a[1], a[3] rise in the same cycle, ready=1, ptr=0. Expect evt_ch sequence 0,1,3 on consecutive cycles, then ptr=0. Repeat: order 0,1,3 again.
- ready=0 while ch3 is offered, then ch0 rises. evt_ch stays 3 until ready. Then 0 is offered next cycle.
- ch2 edge, ready=0 held, second ch2 edge. Expect ovf[2]=1, single ch2 event only. ovf_clr pulse coinciding with a third edge leaves ovf[2]=1. With PULSE_ARB_DROP_CNT_EN: drop_cnt=1.
- Assert rst=0 during OFFER. Next cycle evt_valid=0, ovf=0, pend=0. A held-high input produces a fresh edge event after rst=1.
